// File: rtl/acc_requant_pack.sv
// Accumulator requantizer: bias add, Q31 scale, round/shift, offset, clamp,
// and little-endian packing of int8 results into 32-bit words.
module acc_requant_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [31:0] cfg_bias,
    input  logic [31:0] cfg_mult,
    input  logic [3:0]  cfg_shift,
    input  logic [7:0]  cfg_offset,
    input  logic [7:0]  cfg_act_min,
    input  logic [7:0]  cfg_act_max,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        busy
);

    logic [31:0] bias_q, bias_d;
    logic [31:0] mult_q, mult_d;
    logic [3:0]  shift_q, shift_d;
    logic [7:0]  offset_q, offset_d;
    logic [7:0]  amin_q, amin_d;
    logic [7:0]  amax_q, amax_d;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_last_q, s1_last_d;
    logic [31:0] s1_sum_q, s1_sum_d;
    logic        s2_valid_q, s2_valid_d;
    logic        s2_last_q, s2_last_d;
    logic [63:0] s2_prod_q, s2_prod_d;
    logic        s3_valid_q, s3_valid_d;
    logic        s3_last_q, s3_last_d;
    logic [7:0]  s3_byte_q, s3_byte_d;

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] part_q, part_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_word_q, out_word_d;
    logic        out_last_q, out_last_d;

    logic        advance;
    logic [31:0] merged;

    logic signed [65:0] p_s, rnd_s, r_s, v_s;
    logic signed [65:0] lo_s, hi_s, m_s;
    logic [6:0]         rnd_pos, sh_amt;

    assign advance   = ~out_valid_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_last  = out_last_q;
    assign busy      = s1_valid_q | s2_valid_q | s3_valid_q
                     | (cnt_q != 2'd0) | out_valid_q;

    // Round-half-up at bit (30+shift), then arithmetic shift by (31+shift).
    always_comb begin
        rnd_pos = 7'd30 + {3'b000, shift_q};
        sh_amt  = 7'd31 + {3'b000, shift_q};
        p_s     = $signed({{2{s2_prod_q[63]}}, s2_prod_q});
        rnd_s   = p_s + $signed(66'd1 << rnd_pos);
        r_s     = rnd_s >>> sh_amt;
        v_s     = r_s + $signed({{58{offset_q[7]}}, offset_q});
        lo_s    = $signed({{58{amin_q[7]}}, amin_q});
        hi_s    = $signed({{58{amax_q[7]}}, amax_q});
        m_s     = (v_s < lo_s) ? lo_s : v_s;
        s3_byte_d = (m_s > hi_s) ? amax_q : m_s[7:0];
    end

    always_comb begin
        bias_d   = bias_q;
        mult_d   = mult_q;
        shift_d  = shift_q;
        offset_d = offset_q;
        amin_d   = amin_q;
        amax_d   = amax_q;
        if (cfg_we && !busy) begin
            bias_d   = cfg_bias;
            mult_d   = cfg_mult;
            shift_d  = cfg_shift;
            offset_d = cfg_offset;
            amin_d   = cfg_act_min;
            amax_d   = cfg_act_max;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_sum_d    = s1_sum_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_prod_d   = s2_prod_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        cnt_d       = cnt_q;
        part_d      = part_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        merged      = {8'h00, part_q};
        merged[{cnt_q, 3'b000} +: 8] = s3_byte_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            s1_sum_d   = in_acc + bias_q;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_prod_d  = {{32{s1_sum_q[31]}}, s1_sum_q}
                       * {{32{mult_q[31]}}, mult_q};
            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            out_valid_d = 1'b0;
            if (s3_valid_q) begin
                if (cnt_q == 2'd3 || s3_last_q) begin
                    out_valid_d = 1'b1;
                    out_word_d  = merged;
                    out_last_d  = s3_last_q;
                    cnt_d       = 2'd0;
                    part_d      = 24'd0;
                end else begin
                    part_d = merged[23:0];
                    cnt_d  = cnt_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bias_q      <= 32'd0;
            mult_q      <= 32'h4000_0000;
            shift_q     <= 4'd0;
            offset_q    <= 8'd0;
            amin_q      <= 8'h80;
            amax_q      <= 8'h7F;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= 32'd0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= 64'd0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_byte_q   <= 8'd0;
            cnt_q       <= 2'd0;
            part_q      <= 24'd0;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'd0;
            out_last_q  <= 1'b0;
        end else begin
            bias_q      <= bias_d;
            mult_q      <= mult_d;
            shift_q     <= shift_d;
            offset_q    <= offset_d;
            amin_q      <= amin_d;
            amax_q      <= amax_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_prod_q   <= s2_prod_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            if (advance) s3_byte_q <= s3_byte_d;
            cnt_q       <= cnt_d;
            part_q      <= part_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_acc_requant_pack.sv
// Directed bench for acc_requant_pack with an arithmetic reference model
// and a scoreboard of expected packed words.
module tb_acc_requant_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_bias = '0;
    logic [31:0] cfg_mult = '0;
    logic [3:0]  cfg_shift = '0;
    logic [7:0]  cfg_offset = '0;
    logic [7:0]  cfg_act_min = '0;
    logic [7:0]  cfg_act_max = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic        out_last;
    logic        busy;

    acc_requant_pack dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
        .cfg_shift(cfg_shift), .cfg_offset(cfg_offset),
        .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_bias;
    int          m_mult;
    int          m_shift;
    byte         m_offset;
    byte         m_min;
    byte         m_max;
    logic [31:0] m_word;
    int          m_cnt;
    logic [32:0] exp_q[$];

    logic [31:0] last_word = '0;
    logic        last_flag = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] hold_word = '0;
    logic        hold_last = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bias = 0;
        m_mult = 32'h4000_0000;
        m_shift = 0;
        m_offset = 0;
        m_min = -128;
        m_max = 127;
        m_word = '0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] model_byte(input int acc);
        int     sum;
        longint prod, den, num, r, v;
        sum  = acc + m_bias;
        prod = longint'(sum) * longint'(m_mult);
        den  = longint'(1) << (31 + m_shift);
        num  = prod + den / 2;
        r    = num / den;
        if (num < 0 && (num % den) != 0) r = r - 1;
        v = r + longint'(m_offset);
        if (v < longint'(m_min)) v = longint'(m_min);
        if (v > longint'(m_max)) v = longint'(m_max);
        return v[7:0];
    endfunction

    task automatic model_push(input int acc, input logic last);
        m_word[m_cnt*8 +: 8] = model_byte(acc);
        if (m_cnt == 3 || last) begin
            exp_q.push_back({last, m_word});
            m_word = '0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Every task starts and ends 1ns after a rising edge.
    task automatic send(input int acc, input logic last);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_acc = acc;
        in_last = last;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("accept_timeout", {63'b0, ok}, 64'd1);
        if (ok) model_push(acc, last);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int b, input int m, input int s,
                             input byte o, input byte lo, input byte hi,
                             input logic exp_busy);
        logic bz;
        cfg_we = 1'b1;
        cfg_bias = b;
        cfg_mult = m;
        cfg_shift = s[3:0];
        cfg_offset = o;
        cfg_act_min = lo;
        cfg_act_max = hi;
        @(negedge clk);
        bz = busy;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("cfg_busy", {63'b0, bz}, {63'b0, exp_busy});
        if (!exp_busy) begin
            m_bias = b;
            m_mult = m;
            m_shift = s;
            m_offset = o;
            m_min = lo;
            m_max = hi;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_word", {32'b0, out_word}, 64'd0);
        chk("rst_out_last", {63'b0, out_last}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: check each transferred word and output stability.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                chk("hold_valid", {63'b0, out_valid}, 64'd1);
                chk("hold_word", {32'b0, out_word}, {32'b0, hold_word});
                chk("hold_last", {63'b0, out_last}, {63'b0, hold_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             out_word);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("word", {32'b0, out_word}, {32'b0, e[31:0]});
                    chk("last", {63'b0, out_last}, {63'b0, e[32]});
                end
                last_word = out_word;
                last_flag = out_last;
            end
            stall_prev = out_valid && !out_ready;
            hold_word = out_word;
            hold_last = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int k;
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("init_out_valid", {63'b0, out_valid}, 64'd0);
        chk("init_busy", {63'b0, busy}, 64'd0);
        chk("init_word", {32'b0, out_word}, 64'd0);
        @(posedge clk);
        #1;
        do_reset();

        // defaults: 100,200,-100,300 -> 0x7FCE6432 three edges after last
        send(100, 1'b0);
        send(200, 1'b0);
        send(-100, 1'b0);
        send(300, 1'b1);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                k = i;
                break;
            end
        end
        chk("latency", 64'(k), 64'd4);
        @(posedge clk);
        #1;
        drain();
        chk("lit_basic", {32'b0, last_word}, 64'h7FCE6432);
        chk("lit_basic_last", {63'b0, last_flag}, 64'd1);

        // short tile, then a fresh full word
        send(100, 1'b0);
        send(200, 1'b1);
        drain();
        chk("lit_short", {32'b0, last_word}, 64'h00006432);
        chk("lit_short_last", {63'b0, last_flag}, 64'd1);
        send(2, 1'b0);
        send(4, 1'b0);
        send(6, 1'b0);
        send(8, 1'b0);
        drain();
        chk("lit_fresh", {32'b0, last_word}, 64'h04030201);
        chk("lit_fresh_last", {63'b0, last_flag}, 64'd0);

        // backpressure for 10 cycles with a pending word
        out_ready = 1'b0;
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b0);
        send(40, 1'b0);
        fork
            begin
                send(50, 1'b0);
                send(60, 1'b0);
                send(70, 1'b0);
                send(80, 1'b1);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_wait", {63'b0, out_valid}, 64'd1);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
                    chk("stall_word", {32'b0, out_word}, 64'h140F0A05);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("lit_stall", {32'b0, last_word}, 64'h28231E19);
        chk("lit_stall_last", {63'b0, last_flag}, 64'd1);

        // reset after two accepted inputs discards them
        send(5, 1'b0);
        send(7, 1'b0);
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        send(12, 1'b0);
        send(14, 1'b0);
        send(16, 1'b0);
        send(18, 1'b0);
        drain();
        chk("lit_after_rst", {32'b0, last_word}, 64'h09080706);

        // bias/shift/offset rounding example
        cfg_write(-50, 32'h4000_0000, 1, -128, -128, 127, 1'b0);
        send(250, 1'b1);
        drain();
        chk("lit_cfg", {32'b0, last_word}, 64'h000000B2);

        // inverted clamp bounds give act_max everywhere
        cfg_write(0, 32'h4000_0000, 0, 0, 10, -5, 1'b0);
        send(100, 1'b0);
        send(-3000, 1'b1);
        drain();
        chk("lit_inverted", {32'b0, last_word}, 64'h0000FBFB);

        // config write while busy is ignored
        cfg_write(0, 32'h4000_0000, 0, 0, -128, 127, 1'b0);
        send(100, 1'b0);
        cfg_write(0, 32'h2000_0000, 0, 0, -128, 127, 1'b1);
        send(200, 1'b1);
        drain();
        chk("lit_busy_cfg", {32'b0, last_word}, 64'h00006432);
        send(100, 1'b1);
        drain();
        chk("lit_old_mult", {32'b0, last_word}, 64'h00000032);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_requant_pack.md
ACC_REQUANT_PACK -- requirements
Module: acc_requant_pack

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset), sampled on rising clk.
REQ-003 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-004 SHALL have port cfg_bias, input, 32, signed per-channel bias.
REQ-005 SHALL have port cfg_mult, input, 32, signed Q31 multiplier.
REQ-006 SHALL have port cfg_shift, input, 4, extra right shift (0..15).
REQ-007 SHALL have port cfg_offset, input, 8, signed output zero-point.
REQ-008 SHALL have ports cfg_act_min and cfg_act_max, input, 8 each, signed clamp bounds.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_acc (input, 32, signed MAC accumulator), in_last (input, 1, final accumulator of tile).
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_word (output, 32, packed int8 results), out_last (output, 1).
REQ-011 SHALL have port busy, output, 1, high while any stage or packer holds data.

Function
REQ-012 Config registers SHALL load on cfg_we=1 with busy=0; cfg_we with busy=1 SHALL be ignored.
REQ-013 Input transfer SHALL occur when in_valid and in_ready both 1; output transfer when out_valid and out_ready both 1.
REQ-014 advance = ~out_valid | out_ready; in_ready SHALL equal advance; all pipeline stages SHALL hold when advance=0.
REQ-015 Stage 1 SHALL register sum = in_acc + bias, 32-bit two's-complement wrap.
REQ-016 Stage 2 SHALL register prod = sum * mult, full 64-bit signed.
REQ-017 Stage 3 SHALL compute r = (prod + 2^(30+shift)) >>> (31+shift) (arithmetic), then v = r + offset in >=34 bits, then clamp to [act_min, act_max], yielding one int8 byte.
REQ-018 Packer SHALL place bytes little-endian: k-th byte of a word (k=0..3) into out_word[8k+7:8k]; byte counter wraps 3->0.
REQ-019 Word SHALL become valid when 4th byte packed or when a byte with last flag packed; unused upper bytes SHALL be 0; out_last SHALL be 1 only for the word containing the last byte; byte counter SHALL clear after a last word.
REQ-020 Latency: input accepted at edge N, no stall -> result byte packed at edge N+3; completed word presented with out_valid=1 from edge N+3.
REQ-021 out_word/out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous out transfer and new word completion SHALL present new word next cycle without bubble.
REQ-023 act_min > act_max SHALL yield act_max for every byte (max applied first, then min clamp to max).
REQ-024 Valid bits SHALL propagate with data; bubbles (no input transfer) SHALL not alter packer.

Reset
REQ-025 reset=0 SHALL clear all stage valids, byte counter, out_valid=0, out_word=0, out_last=0, busy=0.
REQ-026 reset=0 SHALL set bias=0, mult=0x40000000, shift=0, offset=0, act_min=-128 (0x80), act_max=127 (0x7F).
REQ-027 Reset mid-operation SHALL discard all in-flight data and partial words; no word emitted afterwards from pre-reset inputs.
REQ-028 in_ready SHALL be 1 in first cycle after reset release.

Verification
REQ-029 Reset defaults, out_ready=1, in_acc = 100, 200, -100, 300 back-to-back, last on 4th -> single word 0x7FCE6432, out_last=1, valid 3 edges after 4th accept.
REQ-030 Inputs 100, 200 with last on 200 -> word 0x00006432, out_last=1; next 4 inputs start at byte 0.
REQ-031 out_ready=0 for 10 cycles while word pending -> out_word stable, in_ready=0, no input lost; release -> stream resumes, outputs match unstalled run.
REQ-032 cfg_bias=-50, cfg_shift=1, cfg_offset=-128, in_acc=250 -> byte ((200*2^30 + 2^31) >>> 32) - 128 = -78 (0xB2).
REQ-033 cfg_we with new mult while busy=1 -> mult unchanged; results of in-flight and subsequent inputs use old value.
REQ-034 reset=0 for one cycle after 2 accepted inputs -> no word emitted, busy=0, next 4 inputs form a fresh word.
